// File: rtl/seg_scan_driver_if.sv
// Bus between the game-play datapath and the seven-segment scanner:
// four per-digit cathode patterns in, scanned anode/cathode drive out.
interface seg_scan_driver_if;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [3:0] an;
  logic [7:0] segOut;
  logic       frameStart;

  modport master (
    output seg0, seg1, seg2, seg3,
    input  an, segOut, frameStart
  );

  modport slave (
    input  seg0, seg1, seg2, seg3,
    output an, segOut, frameStart
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display scanner with per-slot
// blanking and a once-per-frame snapshot of the digit patterns.
module seg_scan_driver #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        Clk100M,
  input  logic        Rst_n,
  seg_scan_driver_if.slave segBus
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cntReg;
  logic [1:0]       digReg;
  logic [7:0]       shadowReg [4];
  logic [7:0]       segIn     [4];
  logic [3:0]       anReg;
  logic [7:0]       segOutReg;
  logic             frameStartReg;
  logic             frameEdge;

  assign segIn[0] = segBus.seg0;
  assign segIn[1] = segBus.seg1;
  assign segIn[2] = segBus.seg2;
  assign segIn[3] = segBus.seg3;

  assign frameEdge = (cntReg == '0) && (digReg == 2'd0);

  // The snapshot lands while cnt==0, which is always blanked, so the
  // cathode bus never changes under a lit anode.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      cntReg        <= '0;
      digReg        <= 2'd0;
      for (int i = 0; i < 4; i++) shadowReg[i] <= 8'hFF;
      anReg         <= 4'b1111;
      segOutReg     <= 8'hFF;
      frameStartReg <= 1'b0;
    end else begin
      if (cntReg == TICK_LAST) begin
        cntReg <= '0;
        digReg <= digReg + 2'd1;
      end else begin
        cntReg <= cntReg + 1'b1;
      end

      if (frameEdge) begin
        for (int i = 0; i < 4; i++) shadowReg[i] <= segIn[i];
      end

      if (cntReg < BLANK_END) begin
        anReg     <= 4'b1111;
        segOutReg <= 8'hFF;
      end else begin
        anReg     <= ~(4'b0001 << digReg);
        segOutReg <= shadowReg[digReg];
      end

      frameStartReg <= frameEdge;
    end
  end

  assign segBus.an         = anReg;
  assign segBus.segOut     = segOutReg;
  assign segBus.frameStart = frameStartReg;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a 16/2 instance and a 4/3 instance
// share clock, reset and digit patterns and are checked every cycle.
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  seg_scan_driver_if bigBus ();
  seg_scan_driver_if smallBus ();

  logic [3:0][7:0] cur;
  logic [3:0][7:0] snapBig;
  logic [3:0][7:0] snapSmall;
  int nCompared = 0;
  int nMismatched = 0;
  int k = 0;

  assign bigBus.seg0   = cur[0];
  assign bigBus.seg1   = cur[1];
  assign bigBus.seg2   = cur[2];
  assign bigBus.seg3   = cur[3];
  assign smallBus.seg0 = cur[0];
  assign smallBus.seg1 = cur[1];
  assign smallBus.seg2 = cur[2];
  assign smallBus.seg3 = cur[3];

  seg_scan_driver #(.TICK_DIV(16), .BLANK_CYCLES(2)) dutBig (
    .Clk100M(clk),
    .Rst_n  (rstN),
    .segBus (bigBus.slave)
  );

  seg_scan_driver #(.TICK_DIV(4), .BLANK_CYCLES(3)) dutSmall (
    .Clk100M(clk),
    .Rst_n  (rstN),
    .segBus (smallBus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    assert (got === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected {frameStart, an, segOut} after edge kk of a scan started at edge 0.
  function automatic logic [12:0] expOut(input int td, input int bc, input int kk,
                                         input logic [3:0][7:0] snap);
    int slot;
    int d;
    logic [3:0] a;
    logic [7:0] s;
    logic fs;
    slot = kk % td;
    d    = (kk / td) % 4;
    fs   = (kk % (4 * td)) == 0;
    if (slot < bc) begin
      a = 4'b1111;
      s = 8'hFF;
    end else begin
      a = 4'b1111 ^ (4'b0001 << d);
      s = snap[d];
    end
    return {fs, a, s};
  endfunction

  task automatic checkReset(input string tag);
    check({tag, " big.an"},     32'(bigBus.an),           32'hF);
    check({tag, " big.seg"},    32'(bigBus.segOut),       32'hFF);
    check({tag, " big.fs"},     32'(bigBus.frameStart),   32'h0);
    check({tag, " small.an"},   32'(smallBus.an),         32'hF);
    check({tag, " small.seg"},  32'(smallBus.segOut),     32'hFF);
    check({tag, " small.fs"},   32'(smallBus.frameStart), 32'h0);
  endtask

  task automatic step();
    logic [12:0] eb;
    logic [12:0] es;
    @(posedge clk);
    #1;
    eb = expOut(16, 2, k, snapBig);
    es = expOut(4, 3, k, snapSmall);
    check($sformatf("big.an k=%0d", k),    32'(bigBus.an),           32'(eb[11:8]));
    check($sformatf("big.seg k=%0d", k),   32'(bigBus.segOut),       32'(eb[7:0]));
    check($sformatf("big.fs k=%0d", k),    32'(bigBus.frameStart),   32'(eb[12]));
    check($sformatf("small.an k=%0d", k),  32'(smallBus.an),         32'(es[11:8]));
    check($sformatf("small.seg k=%0d", k), 32'(smallBus.segOut),     32'(es[7:0]));
    check($sformatf("small.fs k=%0d", k),  32'(smallBus.frameStart), 32'(es[12]));
    check($sformatf("big.onehot k=%0d", k),   32'($countones(~bigBus.an) <= 1), 32'd1);
    check($sformatf("small.onehot k=%0d", k), 32'($countones(~smallBus.an) <= 1), 32'd1);
    if (k % 64 == 0) snapBig = cur;
    if (k % 16 == 0) snapSmall = cur;
    k++;
  endtask

  task automatic runTo(input int n);
    while (k < n) step();
  endtask

  initial begin
    cur = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    snapBig = '1;
    snapSmall = '1;

    // Reset held: outputs must be blank from the asynchronous assertion on.
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #1 checkReset("reset.async0");
    $display("reset held, toggling inputs");
    for (int i = 0; i < 3; i++) begin
      cur = 32'h00FF55AA ^ (32'h11111111 * i);
      @(posedge clk);
      #1 checkReset($sformatf("reset.edge%0d", i));
      #3 checkReset($sformatf("reset.mid%0d", i));
    end
    cur = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    #2 rstN = 1'b1;
    k = 0;

    $display("steady scan frame 0");
    runTo(3);
    check("steady.d0.an", 32'(bigBus.an), 32'hE);
    check("steady.d0.seg", 32'(bigBus.segOut), 32'hC0);
    runTo(19);
    check("steady.d1.an", 32'(bigBus.an), 32'hD);
    check("steady.d1.seg", 32'(bigBus.segOut), 32'hF9);

    $display("tear-free: seg2 -> 99 while digit 1 active");
    cur[2] = 8'h99;
    runTo(35);
    check("tear.d2.oldframe.an", 32'(bigBus.an), 32'hB);
    check("tear.d2.oldframe.seg", 32'(bigBus.segOut), 32'hA4);
    runTo(51);
    check("steady.d3.an", 32'(bigBus.an), 32'h7);
    check("steady.d3.seg", 32'(bigBus.segOut), 32'hB0);
    runTo(65);
    check("cadence.fs64", 32'(bigBus.frameStart), 32'h1);
    runTo(99);
    check("tear.d2.newframe.seg", 32'(bigBus.segOut), 32'h99);
    runTo(169);
    check("midreset.pre.an", 32'(bigBus.an), 32'hB);
    check("midreset.pre.seg", 32'(bigBus.segOut), 32'h99);

    $display("mid-frame reset during digit 2");
    #3 rstN = 1'b0;
    #1 checkReset("midreset.async");
    cur[0] = 8'h88;
    @(posedge clk);
    #1 checkReset("midreset.held0");
    @(posedge clk);
    #1 checkReset("midreset.held1");
    #3 rstN = 1'b1;
    k = 0;
    snapBig = '1;
    snapSmall = '1;

    runTo(3);
    check("midreset.first.an", 32'(bigBus.an), 32'hE);
    check("midreset.first.seg", 32'(bigBus.segOut), 32'h88);
    runTo(4);
    check("paramedge.first.an", 32'(smallBus.an), 32'hE);
    check("paramedge.first.seg", 32'(smallBus.segOut), 32'h88);
    runTo(70);
    $display("scan after reset done, k=%0d", k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It takes the four per-digit segment patterns produced by the game-play datapath (`seg0`..`seg3`) and scans them onto the shared cathode bus and the four anode enables. Each digit gets a blanking interval to suppress ghosting. The four patterns are snapshotted once per frame so a digit never shows a half-updated value. The block sits between the game-play top level and the board pins and is the consumer end of the `segN` interface.

## Interface
Parameters:
- `TICK_DIV`, default 100000: Clk100M cycles per digit slot (1 kHz per digit, 250 Hz frame). Legal range is 2 or more.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot during which all anodes are off. Legal range is 1 to TICK_DIV-1.

Ports:
- `Clk100M`, in, 1: system clock. This block has one clock only.
- `Rst_n`, in, 1: reset, asynchronous and active-low.
- `seg0`..`seg3`, in, 8 each: active-low cathode patterns in order {dp,g,f,e,d,c,b,a}. `seg0` is the rightmost digit.
- `an`, out, 4: active-low anode enables. Bit i enables digit i.
- `segOut`, out, 8: active-low cathode bus, same bit order as the inputs.
- `frameStart`, out, 1: one-cycle pulse marking a new snapshot.

## Operation
- State:
  - `cnt`: slot counter, 0..TICK_DIV-1.
  - `dig`: digit index, 0..3.
  - `shadow[0..3]`: 8-bit snapshot registers.
  - Registered outputs `an`, `segOut`, `frameStart`.
- Counters:
  - `cnt` increments every cycle.
  - When `cnt` reaches TICK_DIV-1 it wraps to 0, and `dig` advances 0→1→2→3→0 on the same edge.
- Frame edge:
  - Defined as `frameEdge = (cnt==0 && dig==0)`.
  - On a frameEdge clock edge, `shadow[i] <= segi` for all four digits simultaneously.
  - The first cycle after reset release is a frame edge.
- Output decode (registered), evaluated from the current `cnt`, `dig` and `shadow`:
  - If `cnt < BLANK_CYCLES`, the next values are `an=4'b1111` and `segOut=8'hFF`.
  - Otherwise, the next value of `an` has only bit `dig` low, and the next value of `segOut` is `shadow[dig]`.
  - The next value of `frameStart` equals `frameEdge`.
- Shadow stability: `shadow` changes only while `cnt==0`, which is always inside the blanking window. The cathode bus therefore never changes while an anode is on.
- Input changes between frame edges are ignored until the next frame edge. There is no handshake, and the inputs are static-sampled.
- Exactly one anode is low at any time, or none. Two anodes are never low in the same cycle.
- Reset (asynchronous, with `Rst_n` low):
  - `cnt=0`, `dig=0`, all `shadow=8'hFF`.
  - `an=4'b1111`, `segOut=8'hFF`, `frameStart=0`.
  - These values apply immediately, without a clock edge.
  - Reset asserted mid-slot or mid-frame aborts the scan.
  - On release, scanning restarts at digit 0 with a fresh snapshot.

## Timing
- Output latency is 1 cycle from the `cnt`/`dig` state.
- Slot length is TICK_DIV cycles.
  - Blank for BLANK_CYCLES cycles.
  - Active for TICK_DIV-BLANK_CYCLES cycles.
- Frame length is 4·TICK_DIV cycles.
- `frameStart`:
  - First pulse occurs on cycle 1 after reset release. Cycle 0 is the first rising edge with `Rst_n` high.
  - Subsequent pulses occur every 4·TICK_DIV cycles.
  - Pulse width is exactly 1 cycle.
- Digit i is visible on outputs from cycle i·TICK_DIV+BLANK_CYCLES+1 through cycle (i+1)·TICK_DIV, relative to the frame edge cycle.
- Snapshot-to-display latency:
  - A change to `segi` is displayed no later than 4·TICK_DIV+(i+1)·TICK_DIV cycles after it occurs.
  - It is never displayed partially within a frame.
- Wrap-around: `cnt` and `dig` wrapping on the same edge is the normal frame boundary. There are no idle cycles between frames.

## Test plan
Use TICK_DIV=16 and BLANK_CYCLES=2 unless stated otherwise.
- **Reset:**
  - Stimulus: hold `Rst_n`=0, toggle the inputs, then assert `Rst_n` low asynchronously between clock edges.
  - Required response: `an`=1111, `segOut`=FF and `frameStart`=0 at all times, changing without waiting for a clock edge.
- **Steady scan:**
  - Stimulus: `seg0`=C0, `seg1`=F9, `seg2`=A4, `seg3`=B0.
  - Required `an` sequence per frame: 1110, 1101, 1011, 0111, each low for exactly 14 cycles.
  - Each digit is preceded by 2 cycles with `an`=1111 and `segOut`=FF.
  - `segOut` is C0/F9/A4/B0 respectively.
- **Tear-free:**
  - Stimulus: change `seg2` from A4 to 99 while digit 1 is active.
  - Required response: digit 2 still shows A4 in the current frame and shows 99 from the next frame onward.
- **frameStart cadence:**
  - Required response: exactly one 1-cycle pulse, the first on cycle 1 after release, then every 64 cycles.
  - A checker confirms that no cycle ever has more than one `an` bit low.
- **Mid-frame reset:**
  - Stimulus: assert `Rst_n` while digit 2 is active, then release with `seg0`=88.
  - Required response: outputs blank immediately; after release, digit 0 is the next digit shown, with value 88.
- **Parameter edge:**
  - Stimulus: TICK_DIV=4, BLANK_CYCLES=3.
  - Required response: each digit is active exactly 1 cycle per 4-cycle slot, the frame is 16 cycles, and the output values are correct.
